// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Instruction buffer between fetch and decode. Each accepted {pc, instr}
//   pair is stored in a small circular FIFO. The head entry is presented
//   already split into MIPS-style fields.
//
//   Handshake: a transfer happens on a rising edge when valid and ready are
//   both high. in_ready depends only on occupancy, so a full queue never
//   accepts a new pair, even when the head is popped on the same edge.
//   out_valid means the head holds a real entry. Head data may not be
//   withdrawn until it is consumed, or until flush or rst clears the queue.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        fetch-side handshake
//     in_pc, in_instr          fetched pair
//     flush                    discard all queued entries (redirect)
//     out_valid/out_ready      decode-side handshake
//     out_pc, out_pc4          head PC and head PC + 4 (mod 2^32)
//     out_instr                head instruction word
//     out_opcode .. out_imm    field slices of out_instr
//     out_is_branch/is_jump    opcode class flags
//     count                    occupancy, 0..DEPTH
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc4,
    output logic [31:0]      out_instr,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [15:0]      out_imm,
    output logic             out_is_branch,
    output logic             out_is_jump,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;

    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Pointers and occupancy. rst wins over flush. Flush wins over any
    // push or pop on the same edge, so the incoming pair is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage has no reset. Entries are only read back while counted valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    // Head outputs are forced to zero while the queue is empty, so
    // stale storage never reaches decode.
    assign w_head_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'd0;
    assign w_head_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'd0;

    assign out_pc    = w_head_pc;
    assign out_pc4   = out_valid ? (w_head_pc + 32'd4) : 32'd0;
    assign out_instr = w_head_instr;

    assign out_opcode = w_head_instr[31:26];
    assign out_rs     = w_head_instr[25:21];
    assign out_rt     = w_head_instr[20:16];
    assign out_rd     = w_head_instr[15:11];
    assign out_shamt  = w_head_instr[10:6];
    assign out_funct  = w_head_instr[5:0];
    assign out_imm    = w_head_instr[15:0];

    // A zeroed head has opcode 0, which matches neither class.
    assign out_is_branch = (w_head_instr[31:26] == 6'b000100) ||
                           (w_head_instr[31:26] == 6'b000101);
    assign out_is_jump   = (w_head_instr[31:26] == 6'b000010) ||
                           (w_head_instr[31:26] == 6'b000011);

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Instruction buffer between the fetch stage (PC counter plus byte-addressed instruction memory) and decode. Captures each fetched {pc, instruction} pair into a small FIFO with valid/ready handshake, supports pipeline flush on control transfer, and presents the head entry pre-split into MIPS-style fields. Decouples fetch from decode stalls without losing or duplicating instructions.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16
PTR_W, 2, pointer width, log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  fetch presents a valid pc/instruction pair
in_pc  in  32  PC of fetched instruction (byte address, multiple of 4)
in_instr  in  32  instruction word, big-endian assembled by fetch
in_ready  out  1  queue can accept this cycle
flush  in  1  discard all queued entries (branch/jump redirect)
out_ready  in  1  decode consumes head this cycle
out_valid  out  1  head entry valid
out_pc  out  32  PC of head
out_pc4  out  32  out_pc + 4, modulo 2^32
out_instr  out  32  head instruction word
out_opcode  out  6  out_instr[31:26]
out_rs  out  5  out_instr[25:21]
out_rt  out  5  out_instr[20:16]
out_rd  out  5  out_instr[15:11]
out_shamt  out  5  out_instr[10:6]
out_funct  out  6  out_instr[5:0]
out_imm  out  16  out_instr[15:0]
out_is_branch  out  1  opcode 6'b000100 or 6'b000101
out_is_jump  out  1  opcode 6'b000010 or 6'b000011
count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0; out_valid=0, in_ready=1; storage contents don't-care.
- in_ready = (count != DEPTH), combinational from count only; never depends on in_valid/out_ready.
- out_valid = (count != 0).
- Push: in_valid && in_ready at edge -> write {in_pc, in_instr} at wr_ptr, wr_ptr+1 (wraps modulo DEPTH).
- Pop: out_valid && out_ready at edge -> rd_ptr+1 (wraps modulo DEPTH).
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop (legal when 0<count<DEPTH).
- Full (count=DEPTH): in_ready=0, in_valid ignored even if pop occurs same cycle; no pass-through. Space visible next cycle.
- Empty (count=0): pop not possible; push with out_ready=1 same cycle: entry written, out_valid rises next cycle. Latency in->out exactly 1 cycle.
- Head outputs combinational from storage[rd_ptr]; when out_valid=0, out_pc, out_pc4, out_instr, all field outputs, out_is_branch, out_is_jump forced to 0.
- Flush: at edge, wr_ptr=rd_ptr=0, count=0; overrides push and pop in same cycle (incoming pair dropped, head not considered consumed). out_valid=0 the cycle after flush.
- rst has priority over flush; reset mid-stream discards contents identically.
- Field decode is pure slicing; no sign extension of out_imm (decode owns that).
- Order strictly FIFO; no entry duplicated or skipped across pointer wrap.

Test Plan:
- Reset then push pc=0x00 instr=0x8C220004, out_ready=0 -> next cycle out_valid=1, out_opcode=6'h23, out_rs=1, out_rt=2, out_imm=0x0004, out_pc4=0x04, count=1.
- Push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0; 5th push pc=0x10 held -> not accepted; then pop 4 -> pcs 0x00..0x0C in order, count=0, out_valid=0.
- Continuous push+pop for 10 cycles (pc 0x00..0x24), both ready -> count stays 1 after first cycle, outputs lag input by one cycle, pointers wrap twice, no loss.
- Fill 3 entries, assert flush with in_valid=1 (pc=0x40) and out_ready=1 -> next cycle count=0, out_valid=0, pc 0x40 absent; subsequent push pc=0x80 appears as head.
- Head instr 0x10220003 -> out_is_branch=1, out_is_jump=0; instr 0x0C000010 -> out_is_jump=1; instr 0x00430820 -> out_rd=1, out_funct=6'h20, both flags 0.
- Assert rst with 2 entries queued and flush=1 -> count=0, in_ready=1, all outputs 0 next cycle; pc=0xFFFFFFFC pushed -> out_pc4=0x00000000.
